// File: rtl/rf_write_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// rf_pkg
// Shared definitions for the register-file write scheduler:
//   DATA_W   - register data width
//   ADDR_W   - register address width
//   NUM_REGS - number of architectural registers (2**ADDR_W)
//   wr_rec_t - one pending register write {addr, data}
// ---------------------------------------------------------------------------
package rf_pkg;

   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 3;
   localparam int NUM_REGS = 1 << ADDR_W;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wr_rec_t;

endpackage

// File: rtl/rf_wr_fifo.sv
// ---------------------------------------------------------------------------
// rf_wr_fifo
// Synchronous FIFO that buffers MD results until the shared write port is free.
// Ports:
//   clk, rst   - clock and synchronous active-high reset (empties the FIFO)
//   push, din  - write one record (ignored while full)
//   pop        - discard the head record (ignored while empty)
//   head       - current head record (valid when !empty)
//   full/empty - occupancy flags, decoded from the registered count
// ---------------------------------------------------------------------------
module rf_wr_fifo
   import rf_pkg::*;
#(
   parameter int BUF_DEPTH = 2
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  wr_rec_t din,
   input  logic    pop,
   output wr_rec_t head,
   output logic    full,
   output logic    empty
);

   localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

   wr_rec_t          mem [BUF_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W:0]   count;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (PTR_W+1)'(BUF_DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign head    = mem[rd_ptr];

   // Pointers wrap naturally because BUF_DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries data only, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/rf_write_scheduler.sv
// ---------------------------------------------------------------------------
// rf_write_scheduler
// Owns the single reg_file write port and shares it between the in-order
// writeback stage (WB, always wins) and buffered multiply/divide results (MD).
// Keeps a per-register pending scoreboard for decode hazard stalls, a sticky
// protocol-violation flag, and a starvation counter that freezes WB when the
// MD buffer stays full.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   wb_we/wb_addr/wb_data        - WB write request
//   md_issue/md_issue_addr       - MD issue, reserves destination register
//   md_valid/md_addr/md_data     - MD result; accepted when md_ready
//   md_ready                     - MD buffer not full
//   id_rs/id_rt, hazard_stall    - decode operands and resulting stall
//   wb_hold                      - WB freeze request (starvation relief)
//   RegWrite/WriteRegister/WriteData - registered reg_file write port
//   pending                      - scoreboard vector
//   waw_err                      - sticky protocol-violation flag
// ---------------------------------------------------------------------------
module rf_write_scheduler
   import rf_pkg::*;
#(
   parameter int BUF_DEPTH  = 2,
   parameter int STARVE_LIM = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                wb_we,
   input  logic [ADDR_W-1:0]   wb_addr,
   input  logic [DATA_W-1:0]   wb_data,
   input  logic                md_issue,
   input  logic [ADDR_W-1:0]   md_issue_addr,
   input  logic                md_valid,
   input  logic [ADDR_W-1:0]   md_addr,
   input  logic [DATA_W-1:0]   md_data,
   output logic                md_ready,
   input  logic [ADDR_W-1:0]   id_rs,
   input  logic [ADDR_W-1:0]   id_rt,
   output logic                hazard_stall,
   output logic                wb_hold,
   output logic                RegWrite,
   output logic [ADDR_W-1:0]   WriteRegister,
   output logic [DATA_W-1:0]   WriteData,
   output logic [NUM_REGS-1:0] pending,
   output logic                waw_err
);

   localparam int CNT_W = $clog2(STARVE_LIM + 1);

   logic              fifo_full;
   logic              fifo_empty;
   wr_rec_t           fifo_head;
   wr_rec_t           md_rec;
   logic              accept;
   logic              drain;

   logic              win_we;
   wr_rec_t           win_rec;
   logic [NUM_REGS-1:0] set_vec;
   logic [NUM_REGS-1:0] clr_vec;
   logic [NUM_REGS-1:0] pending_next;
   logic              err_now;
   logic [CNT_W-1:0]  starve_cnt;
   logic [CNT_W-1:0]  starve_next;

   // md_ready comes from the registered full flag only, so a full buffer never
   // accepts even if it drains at the same edge.
   assign md_ready = ~fifo_full;
   assign accept   = md_valid & ~fifo_full;
   assign drain    = ~wb_we & ~fifo_empty;
   assign md_rec   = '{addr: md_addr, data: md_data};

   rf_wr_fifo #(
      .BUF_DEPTH (BUF_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (accept),
      .din   (md_rec),
      .pop   (drain),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // Register 0 is never marked pending, so it never stalls.
   assign hazard_stall = pending[id_rs] | pending[id_rt];

   // Arbitration and scoreboard next-state
   always_comb begin
      win_we  = 1'b0;
      win_rec = '0;
      set_vec = '0;
      clr_vec = '0;
      err_now = 1'b0;

      if (wb_we) begin
         win_rec = '{addr: wb_addr, data: wb_data};
         win_we  = (wb_addr != '0);
      end else if (drain) begin
         win_rec = fifo_head;
         win_we  = (fifo_head.addr != '0);
         clr_vec[fifo_head.addr] = 1'b1;
      end

      if (md_issue && (md_issue_addr != '0))
         set_vec[md_issue_addr] = 1'b1;

      // A set on the same register as a drain clear takes priority.
      pending_next = (pending & ~clr_vec) | set_vec;

      if (wb_we && pending[wb_addr])
         err_now = 1'b1;
      if (md_issue && pending[md_issue_addr] && !clr_vec[md_issue_addr])
         err_now = 1'b1;
      if (accept && !pending[md_addr])
         err_now = 1'b1;

      if (fifo_full && wb_we)
         starve_next = (starve_cnt == CNT_W'(STARVE_LIM)) ? starve_cnt
                                                         : starve_cnt + 1'b1;
      else
         starve_next = '0;
   end

   // Registered write port, scoreboard, error flag and starvation relief
   always_ff @(posedge clk) begin
      if (rst) begin
         RegWrite      <= 1'b0;
         WriteRegister <= '0;
         WriteData     <= '0;
         pending       <= '0;
         waw_err       <= 1'b0;
         starve_cnt    <= '0;
         wb_hold       <= 1'b0;
      end else begin
         RegWrite      <= win_we;
         WriteRegister <= win_rec.addr;
         WriteData     <= win_rec.data;
         pending       <= pending_next;
         if (err_now) waw_err <= 1'b1;
         starve_cnt    <= starve_next;
         // Hold releases as soon as the buffer frees one slot; WB cannot be
         // writing then, so set and release never coincide.
         if (drain)
            wb_hold <= 1'b0;
         else if (starve_next == CNT_W'(STARVE_LIM))
            wb_hold <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rf_write_scheduler
// Directed scenarios with literal expectations followed by randomized
// traffic, all compared every cycle against a queue-based model.
// ---------------------------------------------------------------------------
module tb_rf_write_scheduler;

   localparam int BUF_DEPTH  = 2;
   localparam int STARVE_LIM = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_we;
   logic [2:0]  wb_addr;
   logic [15:0] wb_data;
   logic        md_issue;
   logic [2:0]  md_issue_addr;
   logic        md_valid;
   logic [2:0]  md_addr;
   logic [15:0] md_data;
   logic        md_ready;
   logic [2:0]  id_rs;
   logic [2:0]  id_rt;
   logic        hazard_stall;
   logic        wb_hold;
   logic        RegWrite;
   logic [2:0]  WriteRegister;
   logic [15:0] WriteData;
   logic [7:0]  pending;
   logic        waw_err;

   rf_write_scheduler #(
      .BUF_DEPTH  (BUF_DEPTH),
      .STARVE_LIM (STARVE_LIM)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .wb_we         (wb_we),
      .wb_addr       (wb_addr),
      .wb_data       (wb_data),
      .md_issue      (md_issue),
      .md_issue_addr (md_issue_addr),
      .md_valid      (md_valid),
      .md_addr       (md_addr),
      .md_data       (md_data),
      .md_ready      (md_ready),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .hazard_stall  (hazard_stall),
      .wb_hold       (wb_hold),
      .RegWrite      (RegWrite),
      .WriteRegister (WriteRegister),
      .WriteData     (WriteData),
      .pending       (pending),
      .waw_err       (waw_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // Behavioural model state
   bit [2:0]  q_addr [$];
   bit [15:0] q_data [$];
   bit [7:0]  pend_m;
   bit        err_m;
   int        run_m;
   bit        hold_m;
   bit        exp_rw;
   bit [2:0]  exp_wr;
   bit [15:0] exp_wd;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit full, acc, pop;
      if (rst) begin
         q_addr.delete(); q_data.delete();
         pend_m = '0; err_m = 0; run_m = 0; hold_m = 0;
         exp_rw = 0; exp_wr = '0; exp_wd = '0;
         return;
      end
      full = (q_addr.size() == BUF_DEPTH);
      acc  = md_valid && !full;
      pop  = !wb_we && (q_addr.size() != 0);
      if (wb_we && pend_m[wb_addr]) err_m = 1;
      if (md_issue && pend_m[md_issue_addr] && !(pop && q_addr[0] == md_issue_addr)) err_m = 1;
      if (acc && !pend_m[md_addr]) err_m = 1;
      if (wb_we) begin
         exp_rw = (wb_addr != 0); exp_wr = wb_addr; exp_wd = wb_data;
      end else if (pop) begin
         exp_rw = (q_addr[0] != 0); exp_wr = q_addr[0]; exp_wd = q_data[0];
      end else begin
         exp_rw = 0; exp_wr = '0; exp_wd = '0;
      end
      if (pop) begin
         pend_m[q_addr[0]] = 0;
         void'(q_addr.pop_front());
         void'(q_data.pop_front());
      end
      if (md_issue && md_issue_addr != 0) pend_m[md_issue_addr] = 1;
      if (acc) begin
         q_addr.push_back(md_addr);
         q_data.push_back(md_data);
      end
      if (full && wb_we) run_m++; else run_m = 0;
      if (pop) hold_m = 0;
      else if (run_m >= STARVE_LIM) hold_m = 1;
   endtask

   task automatic check_comb();
      chk("md_ready", md_ready, q_addr.size() != BUF_DEPTH);
      chk("hazard_stall", hazard_stall, pend_m[id_rs] | pend_m[id_rt]);
   endtask

   task automatic check_regs();
      chk("RegWrite", RegWrite, exp_rw);
      chk("WriteRegister", WriteRegister, exp_wr);
      chk("WriteData", WriteData, exp_wd);
      chk("pending", pending, pend_m);
      chk("waw_err", waw_err, err_m);
      chk("wb_hold", wb_hold, hold_m);
      chk("md_ready_q", md_ready, q_addr.size() != BUF_DEPTH);
   endtask

   // One clock: inputs already driven; check combinational outputs, step the
   // model, then check registered outputs just after the edge.
   task automatic cycle();
      #1;
      check_comb();
      model_edge();
      @(posedge clk);
      #1;
      check_regs();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      rst = 0; wb_we = 0; wb_addr = '0; wb_data = '0;
      md_issue = 0; md_issue_addr = '0; md_valid = 0; md_addr = '0; md_data = '0;
      id_rs = '0; id_rt = '0;
   endtask

   task automatic wb(input logic [2:0] a, input logic [15:0] d);
      wb_we = 1; wb_addr = a; wb_data = d;
   endtask

   initial begin
      idle_inputs();
      rst = 1;
      cycle();
      chk("reset RegWrite", RegWrite, 0);
      chk("reset pending", pending, 0);
      chk("reset md_ready", md_ready, 1);
      idle_inputs();

      // WB only
      wb(3'd7, 16'h0011);
      cycle();
      chk("wb RegWrite", RegWrite, 1);
      chk("wb WriteRegister", WriteRegister, 7);
      chk("wb WriteData", WriteData, 16'h0011);
      chk("wb pending", pending, 0);
      idle_inputs();
      cycle();

      // MD path
      md_issue = 1; md_issue_addr = 3;
      cycle();
      idle_inputs();
      chk("md pending set", pending, 8'b0000_1000);
      id_rs = 3;
      #1;
      chk("md hazard", hazard_stall, 1);
      md_valid = 1; md_addr = 3; md_data = 16'hBEEF;
      cycle();
      idle_inputs();
      chk("md no bypass", RegWrite, 0);
      cycle();
      chk("md RegWrite", RegWrite, 1);
      chk("md WriteRegister", WriteRegister, 3);
      chk("md WriteData", WriteData, 16'hBEEF);
      chk("md pending clr", pending, 0);
      cycle();

      // Contention and starvation relief
      md_issue = 1; md_issue_addr = 5; cycle();
      md_issue_addr = 6; cycle();
      idle_inputs();
      wb(3'd1, 16'h0101); md_valid = 1; md_addr = 5; md_data = 16'h5555; cycle();
      wb(3'd2, 16'h0202); md_addr = 6; md_data = 16'h6666; cycle();
      md_valid = 0;
      chk("cont md_ready", md_ready, 0);
      wb(3'd3, 16'h0303); cycle();
      wb(3'd1, 16'h0111); cycle();
      wb(3'd2, 16'h0222); cycle();
      chk("cont hold early", wb_hold, 0);
      wb(3'd3, 16'h0333); cycle();
      chk("cont hold", wb_hold, 1);
      chk("cont wb write", WriteRegister, 3);
      idle_inputs();
      cycle();
      chk("cont r5 reg", WriteRegister, 5);
      chk("cont r5 data", WriteData, 16'h5555);
      chk("cont hold clr", wb_hold, 0);
      cycle();
      chk("cont r6 reg", WriteRegister, 6);
      chk("cont r6 we", RegWrite, 1);
      chk("cont pending", pending, 0);

      // Register 0
      wb(3'd0, 16'hFFFF); cycle();
      chk("r0 RegWrite", RegWrite, 0);
      idle_inputs();
      md_issue = 1; md_issue_addr = 0; cycle();
      chk("r0 pending", pending, 0);
      idle_inputs();

      // Violation
      md_issue = 1; md_issue_addr = 4; cycle();
      idle_inputs();
      wb(3'd4, 16'h1234); cycle();
      chk("waw flag", waw_err, 1);
      chk("waw write", RegWrite, 1);
      chk("waw data", WriteData, 16'h1234);
      idle_inputs();
      md_valid = 1; md_addr = 4; md_data = 16'h4444; cycle();
      idle_inputs();
      cycle(); cycle();
      chk("waw sticky", waw_err, 1);

      // Reset mid-operation
      md_issue = 1; md_issue_addr = 5; cycle();
      md_issue_addr = 6; cycle();
      idle_inputs();
      wb(3'd1, 16'hAAAA); md_valid = 1; md_addr = 5; md_data = 16'hA5A5; cycle();
      wb(3'd2, 16'hBBBB); md_addr = 6; md_data = 16'hB6B6; cycle();
      idle_inputs();
      chk("mid pending", pending, 8'h60);
      chk("mid full", md_ready, 0);
      rst = 1; cycle();
      rst = 0;
      chk("mid RegWrite", RegWrite, 0);
      chk("mid WriteData", WriteData, 0);
      chk("mid pending0", pending, 0);
      chk("mid waw", waw_err, 0);
      chk("mid ready", md_ready, 1);
      for (int i = 0; i < 3; i++) begin
         cycle();
         chk("mid no stale", RegWrite, 0);
      end

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         rst           = ($urandom_range(0, 199) == 0);
         wb_we         = hold_m ? 1'b0 : ($urandom_range(0, 2) == 0);
         wb_addr       = 3'($urandom);
         wb_data       = 16'($urandom);
         md_issue      = ($urandom_range(0, 3) == 0);
         md_issue_addr = 3'($urandom);
         md_valid      = ($urandom_range(0, 2) == 0);
         md_addr       = 3'($urandom);
         if (pend_m != 0 && $urandom_range(0, 3) != 0) begin
            for (int t = 0; t < 16; t++) begin
               if (pend_m[md_addr]) break;
               md_addr = 3'($urandom);
            end
         end
         md_data = 16'($urandom);
         id_rs   = 3'($urandom);
         id_rt   = 3'($urandom);
         cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Owns the single write port of reg_file (8 x 16-bit) and arbitrates it between two producers: the in-order writeback stage (WB) and the long-latency multiply/divide unit (MD).
- MD results are held in a small FIFO and drained into free write-port slots.
- Keeps a per-register pending scoreboard so decode can stall on operands that an in-flight MD operation has not yet written.
- Sits between the WB/MD units and reg_file, and drives reg_file's RegWrite, WriteRegister and WriteData directly.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 3, register address width
- NUM_REGS, 8, number of architectural registers (2**ADDR_W)
- BUF_DEPTH, 2, MD result FIFO depth (power of 2)
- STARVE_LIM, 4, consecutive full-FIFO cycles before WB hold is requested

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- wb_we  in  1  WB write request
- wb_addr  in  ADDR_W  WB destination register
- wb_data  in  DATA_W  WB write data
- md_issue  in  1  MD operation issued this cycle; reserves its destination
- md_issue_addr  in  ADDR_W  MD destination register at issue
- md_valid  in  1  MD result valid
- md_addr  in  ADDR_W  MD result destination
- md_data  in  DATA_W  MD result data
- md_ready  out  1  FIFO can accept a result (= !fifo_full)
- id_rs  in  ADDR_W  decode source operand 1
- id_rt  in  ADDR_W  decode source operand 2
- hazard_stall  out  1  decode must stall
- wb_hold  out  1  request WB pipeline freeze (starvation relief)
- RegWrite  out  1  to reg_file
- WriteRegister  out  ADDR_W  to reg_file
- WriteData  out  DATA_W  to reg_file
- pending  out  NUM_REGS  scoreboard bit vector
- waw_err  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst=1 at a clk edge): RegWrite=0, WriteRegister=0, WriteData=0, FIFO empty, pending=0, waw_err=0, wb_hold=0, starvation counter=0. Reset mid-operation discards buffered MD results.
- Write-port outputs are registered, so each write is presented one cycle after its arbitration decision.
- Arbitration per cycle:
  - If wb_we=1, WB wins.
  - Else if the FIFO is non-empty, the FIFO head wins and is popped at that edge.
  - Else RegWrite=0 next cycle.
- Register 0 is hardwired zero: any winner with address 0 produces RegWrite=0. It is still popped or consumed.
- MD handshake: a result is accepted at an edge with md_valid & md_ready and pushed into the FIFO. No bypass path exists. Minimum latency is accept at edge N, drain at edge N+1, RegWrite=1 during cycle N+1→N+2.
- Full FIFO: md_ready=0 and the producer holds its data. A push and pop in the same cycle while full is not permitted, because md_ready is derived from registered full only.
- Scoreboard:
  - md_issue with md_issue_addr≠0 sets pending[addr].
  - A FIFO drain win clears pending[md_addr].
  - If a set and a clear hit the same register at the same edge, the set wins.
- hazard_stall (combinational) = pending[id_rs] | pending[id_rt]. Address 0 never stalls.
- waw_err is set, and held until rst, on any of:
  - wb_we to a pending register;
  - md_issue to an already pending register, unless that register is cleared at the same edge;
  - an accepted md_valid whose md_addr is not pending.
  The offending operation is still carried out.
- Starvation:
  - The counter increments each cycle the FIFO is full and wb_we=1, and resets otherwise.
  - When the counter reaches STARVE_LIM, wb_hold=1 starting the next cycle. It drops in the cycle after the FIFO drains one entry.
  - The WB stage guarantees wb_we=0 while wb_hold=1.

Decomposition:
- Shared package rf_pkg: DATA_W, ADDR_W, NUM_REGS, and a typedef for a {addr,data} write record.
- One sub-module, rf_wr_fifo: synchronous FIFO with push/pop/full/empty and depth BUF_DEPTH. Its reset follows the same rst.
- Arbitration, scoreboard, starvation counter and output registers stay in the top module.

Test Plan:
- WB only: wb_we=1, wb_addr=7, wb_data=16'h0011 → next cycle RegWrite=1, WriteRegister=7, WriteData=16'h0011; pending stays 0.
- MD path: md_issue to r3 → pending=8'b0000_1000 and hazard_stall=1 for id_rs=3. Then md_valid with r3/16'hBEEF while wb_we=0 → RegWrite=1, WriteRegister=3, WriteData=16'hBEEF two cycles after accept; pending returns to 0.
- Contention: WB writes r1,r2,r3 back-to-back while MD pushes r5 and r6 → FIFO fills, md_ready=0, and after STARVE_LIM=4 full+WB cycles wb_hold=1. After wb_we drops, r5 then r6 are written and wb_hold clears.
- Register 0: wb_we=1 to r0 with data 16'hFFFF → RegWrite stays 0. md_issue to r0 → pending unchanged.
- Violation: with r4 pending, wb_we=1 to r4 → waw_err=1, the write still occurs, and waw_err stays 1 until rst.
- Reset mid-operation: FIFO holds 2 entries and pending=8'h60, then assert rst for one edge → all outputs 0, md_ready=1, and no stale write appears afterwards.
